// File: rtl/descrambler_sync_controller.sv
// Sequencing/lock controller for one triplicated 30-bit self-synchronising descrambler lane.
// Latency: every output is registered; decisions take effect on the edge after their inputs are sampled.
// Backpressure: none accepted; frames are observed as presented, and frameValid alone paces SEED.
//
// Ports:
//   clock, reset         single clock, synchronous active-low reset
//   frameValid           scrambled frame entering the descrambler this cycle
//   rxData               registered descrambler output (aligned with dataValid)
//   frameError           downstream bad-frame flag, honoured only on qualified frames in LOCKED
//   resyncRequest        level, forces RESET_DS from any state (no lossOfLock)
//   deScramblerReset     active-low reset to the descrambler registers
//   deScrambleEnable     descrambler flow-control enable
//   dataValid            frameValid delayed one cycle, held low in RESET_DS
//   locked, lossOfLock   lock status and one-cycle error-driven loss pulse
//   errorCount           saturating count of qualified errors seen while locked
//   syncState            0 RESET_DS, 1 SEED, 2 HUNT, 3 LOCKED
module descrambler_sync_controller #(
    parameter logic [29:0] IDLE_PATTERN = 30'h0000_0000,
    parameter int          RESET_CYCLES = 4,
    parameter int          SEED_FRAMES  = 2,
    parameter int          LOCK_COUNT   = 16,
    parameter int          HUNT_TIMEOUT = 1024,
    parameter int          WINDOW       = 64,
    parameter int          ERR_LIMIT    = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frameValid,
    input  logic [29:0] rxData,
    input  logic        frameError,
    input  logic        resyncRequest,
    output logic        deScramblerReset,
    output logic        deScrambleEnable,
    output logic        dataValid,
    output logic        locked,
    output logic        lossOfLock,
    output logic [7:0]  errorCount,
    output logic [1:0]  syncState
);

    localparam logic [1:0] S_RESET_DS = 2'd0;
    localparam logic [1:0] S_SEED     = 2'd1;
    localparam logic [1:0] S_HUNT     = 2'd2;
    localparam logic [1:0] S_LOCKED   = 2'd3;

    // Terminal values; the RESET_DS and SEED counters compare against N-1 so
    // the transition lands on the Nth cycle / frame without an extra state.
    localparam logic [7:0]  RESET_LAST = 8'(RESET_CYCLES - 1);
    localparam logic [7:0]  SEED_LAST  = 8'(SEED_FRAMES - 1);
    localparam logic [7:0]  LOCK_TGT   = 8'(LOCK_COUNT);
    localparam logic [15:0] TMO_TGT    = 16'(HUNT_TIMEOUT);
    localparam logic [7:0]  WIN_TGT    = 8'(WINDOW);
    localparam logic [7:0]  ERR_TGT    = 8'(ERR_LIMIT);

    logic [1:0]  state_q,    state_d;
    logic [7:0]  rst_cnt_q,  rst_cnt_d;
    logic [7:0]  seed_cnt_q, seed_cnt_d;
    logic [7:0]  good_cnt_q, good_cnt_d;
    logic [15:0] tmo_cnt_q,  tmo_cnt_d;
    logic [7:0]  win_cnt_q,  win_cnt_d;
    logic [7:0]  werr_cnt_q, werr_cnt_d;
    logic [7:0]  err_cnt_q,  err_cnt_d;
    logic        ds_rst_n_q, ds_rst_n_d;
    logic        ds_en_q,    ds_en_d;
    logic        data_valid_q, data_valid_d;
    logic        locked_q,   locked_d;
    logic        lol_q,      lol_d;

    logic        go_reset;
    logic [7:0]  good_inc;
    logic [15:0] tmo_inc;
    logic [7:0]  win_inc;
    logic [7:0]  werr_inc;

    always_comb begin
        state_d    = state_q;
        rst_cnt_d  = rst_cnt_q;
        seed_cnt_d = seed_cnt_q;
        good_cnt_d = good_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        win_cnt_d  = win_cnt_q;
        werr_cnt_d = werr_cnt_q;
        err_cnt_d  = err_cnt_q;
        lol_d      = 1'b0;
        go_reset   = 1'b0;
        good_inc   = 8'd0;
        tmo_inc    = 16'd0;
        win_inc    = 8'd0;
        werr_inc   = 8'd0;

        if (resyncRequest) begin
            // Outranks everything, including an error arriving this cycle,
            // so errorCount is left untouched.
            go_reset = 1'b1;
        end else begin
            case (state_q)
                S_RESET_DS: begin
                    if (rst_cnt_q == RESET_LAST) begin
                        state_d    = S_SEED;
                        seed_cnt_d = 8'd0;
                    end else begin
                        rst_cnt_d = rst_cnt_q + 8'd1;
                    end
                end
                S_SEED: begin
                    // Seed frames are counted at the descrambler input, not on dataValid.
                    if (frameValid) begin
                        if (seed_cnt_q == SEED_LAST) begin
                            state_d    = S_HUNT;
                            good_cnt_d = 8'd0;
                            tmo_cnt_d  = 16'd0;
                        end else begin
                            seed_cnt_d = seed_cnt_q + 8'd1;
                        end
                    end
                end
                S_HUNT: begin
                    if (data_valid_q) begin
                        good_inc   = (rxData == IDLE_PATTERN) ? good_cnt_q + 8'd1 : 8'd0;
                        tmo_inc    = tmo_cnt_q + 16'd1;
                        good_cnt_d = good_inc;
                        tmo_cnt_d  = tmo_inc;
                        // Lock beats timeout if both land on the same frame.
                        if (good_inc == LOCK_TGT) begin
                            state_d    = S_LOCKED;
                            win_cnt_d  = 8'd0;
                            werr_cnt_d = 8'd0;
                        end else if (tmo_inc == TMO_TGT) begin
                            go_reset = 1'b1;
                        end
                    end
                end
                default: begin // S_LOCKED
                    if (data_valid_q) begin
                        win_inc  = win_cnt_q + 8'd1;
                        werr_inc = werr_cnt_q + {7'd0, frameError};
                        if (frameError && (err_cnt_q != 8'hFF)) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                        // Error limit outranks the window rollover on the same frame.
                        if (werr_inc == ERR_TGT) begin
                            go_reset = 1'b1;
                            lol_d    = 1'b1;
                        end else if (win_inc == WIN_TGT) begin
                            win_cnt_d  = 8'd0;
                            werr_cnt_d = 8'd0;
                        end else begin
                            win_cnt_d  = win_inc;
                            werr_cnt_d = werr_inc;
                        end
                    end
                end
            endcase
        end

        if (go_reset) begin
            state_d    = S_RESET_DS;
            rst_cnt_d  = 8'd0;
            seed_cnt_d = 8'd0;
            good_cnt_d = 8'd0;
            tmo_cnt_d  = 16'd0;
            win_cnt_d  = 8'd0;
            werr_cnt_d = 8'd0;
        end

        // Outputs are derived from the next state so they change on the
        // same edge as syncState.
        ds_rst_n_d   = (state_d != S_RESET_DS);
        ds_en_d      = (state_d != S_RESET_DS);
        data_valid_d = frameValid && (state_d != S_RESET_DS);
        locked_d     = (state_d == S_LOCKED);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= S_RESET_DS;
            rst_cnt_q    <= 8'd0;
            seed_cnt_q   <= 8'd0;
            good_cnt_q   <= 8'd0;
            tmo_cnt_q    <= 16'd0;
            win_cnt_q    <= 8'd0;
            werr_cnt_q   <= 8'd0;
            err_cnt_q    <= 8'd0;
            ds_rst_n_q   <= 1'b0;
            ds_en_q      <= 1'b0;
            data_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            lol_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            seed_cnt_q   <= seed_cnt_d;
            good_cnt_q   <= good_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            win_cnt_q    <= win_cnt_d;
            werr_cnt_q   <= werr_cnt_d;
            err_cnt_q    <= err_cnt_d;
            ds_rst_n_q   <= ds_rst_n_d;
            ds_en_q      <= ds_en_d;
            data_valid_q <= data_valid_d;
            locked_q     <= locked_d;
            lol_q        <= lol_d;
        end
    end

    assign deScramblerReset = ds_rst_n_q;
    assign deScrambleEnable = ds_en_q;
    assign dataValid        = data_valid_q;
    assign locked           = locked_q;
    assign lossOfLock       = lol_q;
    assign errorCount       = err_cnt_q;
    assign syncState        = state_q;

endmodule
